// File: rtl/exec_pkg.sv
// exec_pkg: shared state encoding, ALU codes and parameter checks for the execute unit
package exec_pkg;
    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} execState_e;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_REGW = 5;
    localparam int DEF_CTRLW = 4;
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_SLT = 5;
    localparam int ALU_SLTU = 6;
    localparam int ALU_SLL = 7;
    localparam int ALU_SRL = 8;
    localparam int ALU_SRA = 9;
    function automatic bit bpcLegal(input int width, input int bpc);
        return (bpc == 1 || bpc == 2 || bpc == 4) && (width % bpc == 0);
    endfunction
endpackage

// File: rtl/alu.sv
// alu: single-cycle combinational integer ALU; unknown control codes yield zero
module alu
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CTRLW = DEF_CTRLW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CTRLW-1:0] ctrl,
    output logic [WIDTH-1:0] y
);
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] shamt;
    logic [WIDTH-1:0] sra;
    logic lessS, lessU;
    assign shamt = b[SHW-1:0];
    assign sra = $signed(a) >>> shamt;
    assign lessS = $signed(a) < $signed(b);
    assign lessU = a < b;
    // Signed results are computed apart so the ternary chain stays unsigned-safe
    always_comb
        y = ctrl == CTRLW'(ALU_ADD)  ? a + b :
            ctrl == CTRLW'(ALU_SUB)  ? a - b :
            ctrl == CTRLW'(ALU_AND)  ? a & b :
            ctrl == CTRLW'(ALU_OR)   ? a | b :
            ctrl == CTRLW'(ALU_XOR)  ? a ^ b :
            ctrl == CTRLW'(ALU_SLT)  ? WIDTH'(lessS) :
            ctrl == CTRLW'(ALU_SLTU) ? WIDTH'(lessU) :
            ctrl == CTRLW'(ALU_SLL)  ? a << shamt :
            ctrl == CTRLW'(ALU_SRL)  ? a >> shamt :
            ctrl == CTRLW'(ALU_SRA)  ? sra : '0;
endmodule

// File: rtl/mul_iter_step.sv
// mul_iter_step: adds BPC shifted partial products of the multiplicand into the accumulator
module mul_iter_step #(
    parameter int WIDTH = 32,
    parameter int BPC = 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [BPC-1:0]     mplierBits,
    output logic [2*WIDTH-1:0] accNext
);
    // Multiplier bit i selects mcand shifted by i
    always_comb begin
        accNext = acc;
        for (int i = 0; i < BPC; i++)
            accNext = accNext + (mplierBits[i] ? mcand << i : '0);
    end
endmodule

// File: rtl/multicycle_exec_unit.sv
// multicycle_exec_unit: handshaked execute stage with 1-cycle ALU and iterative shift-add multiplier
module multicycle_exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REGW = DEF_REGW,
    parameter int CTRLW = DEF_CTRLW,
    parameter int MUL_BPC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic             in_mul,
    input  logic             in_signed,
    input  logic [REGW-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [REGW-1:0]  out_rd
);
    localparam int K = WIDTH / MUL_BPC;
    localparam int CW = $clog2(K + 1);
    if (!bpcLegal(WIDTH, MUL_BPC)) begin : gBadBpc
        $error("MUL_BPC must be 1, 2 or 4 and divide WIDTH");
    end
    execState_e state, stateNext;
    logic [2*WIDTH-1:0] mcand, acc, accNext, product;
    logic [WIDTH-1:0] mplier, magA, magB, aluY, outLo, outHi;
    logic [REGW-1:0] outRd;
    logic [CW-1:0] cnt;
    logic sign, accept, lastStep;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign out_lo = outLo;
    assign out_hi = outHi;
    assign out_rd = outRd;
    assign accept = in_ready && in_valid;
    assign lastStep = state == MUL_RUN && cnt == CW'(K - 1);
    assign magA = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign magB = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign product = sign ? -accNext : accNext;
    alu #(.WIDTH(WIDTH), .CTRLW(CTRLW)) uAlu (.a(in_a), .b(in_b), .ctrl(in_ctrl), .y(aluY));
    mul_iter_step #(.WIDTH(WIDTH), .BPC(MUL_BPC)) uStep (
        .acc(acc), .mcand(mcand), .mplierBits(mplier[MUL_BPC-1:0]), .accNext(accNext)
    );
    // State register
    always_ff @(posedge clk)
        state <= reset ? IDLE : stateNext;
    // Next state; flush returns to IDLE from anywhere and blocks a same-cycle accept
    always_comb begin
        stateNext = state;
        stateNext = flush             ? IDLE :
                    state == IDLE     ? (in_valid ? (in_mul ? MUL_RUN : DONE) : IDLE) :
                    state == MUL_RUN  ? (lastStep ? DONE : MUL_RUN) :
                    out_ready         ? IDLE : DONE;
    end
    // Operand latch at accept, one multiply step per MUL_RUN cycle, result load on the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            cnt <= '0;
            sign <= 1'b0;
            outLo <= '0;
            outHi <= '0;
            outRd <= '0;
        end else if (!flush) begin
            if (accept) begin
                outRd <= in_rd;
                if (in_mul) begin
                    mcand <= {{WIDTH{1'b0}}, magA};
                    mplier <= magB;
                    acc <= '0;
                    cnt <= '0;
                    sign <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                end else begin
                    outLo <= aluY;
                    outHi <= '0;
                end
            end else if (state == MUL_RUN) begin
                acc <= accNext;
                mcand <= mcand << MUL_BPC;
                mplier <= mplier >> MUL_BPC;
                cnt <= cnt + 1'b1;
                if (lastStep)
                    {outHi, outLo} <= product;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_exec_unit.sv
// tb_multicycle_exec_unit: directed vector table plus corner sequences on BPC=1 and BPC=4 instances
module tb_multicycle_exec_unit;
    import exec_pkg::*;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        mul;
        logic        sgn;
        logic [4:0]  rd;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic [31:0] inA = '0, inB = '0;
    logic [3:0] inCtrl = '0;
    logic inMul = 1'b0, inSigned = 1'b0;
    logic [4:0] inRd = '0;
    logic rdy1, vld1, rdy4, vld4;
    logic [31:0] lo1, hi1, lo4, hi4;
    logic [4:0] rd1, rd4;
    int nCmp = 0, nBad = 0;
    vec_t vecs[19];
    always #5 clk = ~clk;
    multicycle_exec_unit #(.WIDTH(32), .REGW(5), .CTRLW(4), .MUL_BPC(1)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(rdy1),
        .in_a(inA), .in_b(inB), .in_ctrl(inCtrl), .in_mul(inMul), .in_signed(inSigned),
        .in_rd(inRd), .out_valid(vld1), .out_ready(outReady), .out_lo(lo1), .out_hi(hi1),
        .out_rd(rd1)
    );
    multicycle_exec_unit #(.WIDTH(32), .REGW(5), .CTRLW(4), .MUL_BPC(4)) u4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(rdy4),
        .in_a(inA), .in_b(inB), .in_ctrl(inCtrl), .in_mul(inMul), .in_signed(inSigned),
        .in_rd(inRd), .out_valid(vld4), .out_ready(outReady), .out_lo(lo4), .out_hi(hi4),
        .out_rd(rd4)
    );
    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] sa, sb;
        sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic offer(input vec_t v);
        inA = v.a;
        inB = v.b;
        inCtrl = v.ctrl;
        inMul = v.mul;
        inSigned = v.sgn;
        inRd = v.rd;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        inA = $urandom;
        inB = $urandom;
        inCtrl = 4'($urandom);
        inMul = ~inMul;
        inSigned = ~inSigned;
        inRd = ~inRd;
    endtask
    task automatic runOp(input vec_t v, input string nm);
        int lat1, lat4;
        lat1 = 0;
        lat4 = 0;
        offer(v);
        for (int c = 1; c <= 60; c++) begin
            if (lat1 == 0 && vld1) lat1 = c;
            if (lat4 == 0 && vld4) lat4 = c;
            if (lat1 != 0 && lat4 != 0) break;
            tick();
        end
        chk({nm, " lat1"}, 80'(lat1), 80'(v.mul ? 33 : 1));
        chk({nm, " lat4"}, 80'(lat4), 80'(v.mul ? 9 : 1));
        chk({nm, " res1"}, {11'b0, hi1, lo1, rd1}, {11'b0, v.hi, v.lo, v.rd});
        chk({nm, " res4"}, {11'b0, hi4, lo4, rd4}, {11'b0, v.hi, v.lo, v.rd});
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk({nm, " handoff"}, 80'({rdy1, vld1, rdy4, vld4}), 80'(4'b1010));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t v;
        int seen;
        logic [63:0] p;
        vecs[0]  = '{32'd5, 32'd7, 4'(ALU_ADD), 1'b0, 1'b0, 5'd3, 32'd12, 32'd0};
        vecs[1]  = '{32'd5, 32'd7, 4'(ALU_SUB), 1'b0, 1'b0, 5'd4, 32'hFFFFFFFE, 32'd0};
        vecs[2]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'(ALU_AND), 1'b0, 1'b0, 5'd5, 32'hF000F000, 32'd0};
        vecs[3]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'(ALU_OR), 1'b0, 1'b0, 5'd6, 32'hFFF0FFF0, 32'd0};
        vecs[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'(ALU_XOR), 1'b0, 1'b0, 5'd7, 32'h0FF00FF0, 32'd0};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1, 4'(ALU_SLT), 1'b0, 1'b0, 5'd8, 32'd1, 32'd0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1, 4'(ALU_SLTU), 1'b0, 1'b0, 5'd9, 32'd0, 32'd0};
        vecs[7]  = '{32'd1, 32'd4, 4'(ALU_SLL), 1'b0, 1'b0, 5'd10, 32'd16, 32'd0};
        vecs[8]  = '{32'h80000000, 32'd4, 4'(ALU_SRL), 1'b0, 1'b0, 5'd11, 32'h08000000, 32'd0};
        vecs[9]  = '{32'h80000000, 32'd4, 4'(ALU_SRA), 1'b0, 1'b0, 5'd12, 32'hF8000000, 32'd0};
        vecs[10] = '{32'hFFFFFFFF, 32'd2, 4'd0, 1'b1, 1'b0, 5'd13, 32'hFFFFFFFE, 32'd1};
        vecs[11] = '{32'hFFFFFFFD, 32'd7, 4'd0, 1'b1, 1'b1, 5'd14, 32'hFFFFFFEB, 32'hFFFFFFFF};
        vecs[12] = '{32'h80000000, 32'h80000000, 4'd0, 1'b1, 1'b1, 5'd15, 32'd0, 32'h40000000};
        vecs[13] = '{32'd123, 32'd456, 4'(ALU_SUB), 1'b1, 1'b1, 5'd16, 32'd56088, 32'd0};
        vecs[14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 1'b1, 1'b0, 5'd17, 32'h00000001, 32'hFFFFFFFE};
        vecs[15] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 1'b1, 1'b1, 5'd18, 32'd1, 32'd0};
        vecs[16] = '{32'd7, 32'h80000000, 4'd0, 1'b1, 1'b1, 5'd19, 32'h80000000, 32'hFFFFFFFC};
        vecs[17] = '{32'h80000000, 32'd7, 4'd0, 1'b1, 1'b0, 5'd20, 32'h80000000, 32'd3};
        vecs[18] = '{32'd6, 32'd7, 4'(ALU_XOR), 1'b1, 1'b0, 5'd21, 32'd42, 32'd0};
        tick();
        tick();
        reset = 1'b0;
        chk("reset u1", {42'b0, rdy1, vld1, hi1[0], lo1, rd1}, {42'b0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0});
        chk("reset u4", {10'b0, rdy4, vld4, hi4, lo4, rd4}, 80'h0 | (80'b1 << 70));
        for (int i = 0; i < 19; i++) runOp(vecs[i], $sformatf("vec%0d", i));
        offer(vecs[0]);
        inValid = 1'b1;
        inMul = 1'b0;
        inCtrl = 4'(ALU_SUB);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall%0d u1", c), {41'b0, vld1, rdy1, lo1, rd1}, {41'b0, 1'b1, 1'b0, 32'd12, 5'd3});
            chk($sformatf("stall%0d u4", c), {9'b0, vld4, rdy4, hi4, lo4, rd4}, {9'b0, 1'b1, 1'b0, 32'd0, 32'd12, 5'd3});
            tick();
        end
        inValid = 1'b0;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("stall release", 80'({rdy1, vld1, rdy4, vld4}), 80'(4'b1010));
        runOp(vecs[1], "after stall");
        offer(vecs[12]);
        for (int c = 1; c < 12; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush mid-mul", 80'({rdy1, vld1, rdy4, vld4}), 80'(4'b1010));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            seen += int'(vld1) + int'(vld4);
            tick();
        end
        chk("flush no valid", 80'(seen), 80'(0));
        inA = 32'd1;
        inB = 32'd1;
        inCtrl = 4'(ALU_ADD);
        inMul = 1'b0;
        inValid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        chk("flush beats accept", 80'({rdy1, vld1, rdy4, vld4}), 80'(4'b1010));
        tick();
        chk("flush beats accept later", 80'({rdy1, vld1, rdy4, vld4}), 80'(4'b1010));
        runOp(vecs[11], "after flush");
        v = '{32'h80000000, 32'h80000000, 4'd0, 1'b1, 1'b1, 5'd31, 32'd0, 32'h40000000};
        offer(v);
        for (int c = 1; c < 5; c++) tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        chk("reset mid-mul u1", {9'b0, rdy1, vld1, hi1, lo1, rd1}, {9'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0});
        chk("reset mid-mul u4", {9'b0, rdy4, vld4, hi4, lo4, rd4}, {9'b0, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0});
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            seen += int'(vld1) + int'(vld4);
            tick();
        end
        chk("reset no valid", 80'(seen), 80'(0));
        for (int i = 0; i < 20; i++) begin
            v.a = (i % 5 == 0) ? 32'h80000000 : $urandom;
            v.b = (i % 7 == 3) ? 32'hFFFFFFFF : $urandom;
            v.ctrl = 4'($urandom);
            v.mul = 1'b1;
            v.sgn = 1'($urandom);
            v.rd = 5'($urandom);
            p = model(v.a, v.b, v.sgn);
            v.lo = p[31:0];
            v.hi = p[63:32];
            runOp(v, $sformatf("rand%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
